// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional macro FIFO_WR_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 8,
    parameter int BURST_LEN   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_REQ-1:0]            src_valid,
    output logic [NUM_REQ-1:0]            src_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_wr_full,
    input  logic [DEPTH_WIDTH:0]          fifo_wr_water_level,
    output logic                          overflow_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [DEPTH_WIDTH:0] CAPACITY   = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] BURST_NEED = (DEPTH_WIDTH + 1)'(BURST_LEN);
    localparam logic [CNT_W-1:0]     LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0]     PTR_INIT   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        SETTLE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DEPTH_WIDTH:0]  free_space;
    logic                  space_ok;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      cur;
    logic [PTR_W-1:0]      pick;
    logic                  pick_valid;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  settle_cnt;
    logic                  accept;
    logic                  last_beat;
    logic                  start_burst;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DATA_WIDTH-1:0] src_chunk [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src_chunk[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Free space is taken modulo 2**(DEPTH_WIDTH+1), so a full FIFO reads as zero free words.
    assign free_space = CAPACITY - fifo_wr_water_level;
    assign space_ok   = (free_space >= BURST_NEED);

    // Winner search: first active request after rr_ptr, wrapping around.
    always_comb begin
        int             idx;
        logic [PTR_W-1:0] idx_p;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        idx_p      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_p = PTR_W'(idx);
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (!pick_valid && (idx != 0) && req[idx_p]) begin
`else
            if (!pick_valid && req[idx_p]) begin
`endif
                pick       = idx_p;
                pick_valid = 1'b1;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req[0]) begin
            pick       = '0;
            pick_valid = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_burst) state_next = BURST;
            BURST:   if (last_beat)   state_next = SETTLE;
            SETTLE:  if (settle_cnt)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready   = grant & {NUM_REQ{~fifo_wr_full}};
        accept      = (state == BURST) && |(src_ready & src_valid);
        last_beat   = accept && (beat_cnt == LAST_BEAT);
        start_burst = (state == IDLE) && pick_valid && space_ok;
        cur_data    = src_chunk[cur];
    end

    // Grant, pointer, beat counting and the registered FIFO write side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant        <= '0;
            rr_ptr       <= PTR_INIT;
            cur          <= '0;
            beat_cnt     <= '0;
            settle_cnt   <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            overflow_err <= 1'b0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_wr_data <= cur_data;
            end
            if (fifo_wr_en && fifo_wr_full) begin
                overflow_err <= 1'b1;
            end
            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
            if (start_burst) begin
                grant    <= NUM_REQ'(1) << pick;
                cur      <= pick;
                beat_cnt <= '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
                if (pick != '0) begin
                    rr_ptr <= pick;
                end
`else
                rr_ptr <= pick;
`endif
            end
            if (accept) begin
                if (last_beat) begin
                    grant    <= '0;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a burst-level reference model.
// Honours FIFO_WR_ARB_PRIO0_EN in both the model and the directed expectations.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int DEPTH_WIDTH = 8;
    localparam int BURST_LEN   = 16;
    localparam int CAP         = 1 << DEPTH_WIDTH;
    localparam int IW          = $clog2(NUM_REQ);

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_REQ-1:0]            req = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] src_data = '0;
    logic [NUM_REQ-1:0]            src_valid = '0;
    logic [NUM_REQ-1:0]            src_ready;
    logic [NUM_REQ-1:0]            grant;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_en;
    logic                          fifo_wr_full = 1'b0;
    logic [DEPTH_WIDTH:0]          fifo_wr_water_level = '0;
    logic                          overflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the port, how far into the burst, and the settle hold-off.
    int                    m_owner = -1;
    int                    m_beats = 0;
    int                    m_block = 0;
    int                    m_last  = NUM_REQ - 1;
    logic                  m_wr_en = 1'b0;
    logic [DATA_WIDTH-1:0] m_wr_data = '0;
    logic                  m_ovf = 1'b0;

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_WIDTH(DEPTH_WIDTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .grant(grant),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_full(fifo_wr_full),
        .fifo_wr_water_level(fifo_wr_water_level),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int pick_winner(input logic [NUM_REQ-1:0] r, input int last);
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx = (last + k) % NUM_REQ;
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (idx == 0) continue;
`endif
            if (r[IW'(idx)]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int   free;
        int   w;
        logic acc;
        free = CAP - int'(fifo_wr_water_level);
        if (m_wr_en && fifo_wr_full) m_ovf = 1'b1;
        m_wr_en = 1'b0;
        if (m_owner >= 0) begin
            acc = src_valid[IW'(m_owner)] && !fifo_wr_full;
            if (acc) begin
                m_wr_en   = 1'b1;
                m_wr_data = src_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
                m_beats++;
                if (m_beats == BURST_LEN) begin
                    m_owner = -1;
                    m_block = 2;
                end
            end
        end else if (m_block > 0) begin
            m_block--;
        end else if (free >= BURST_LEN) begin
            w = pick_winner(req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_beats = 0;
`ifdef FIFO_WR_ARB_PRIO0_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
            end
        end
    endtask

    // Single compare process: outputs are checked mid-cycle, then the model advances one edge.
    always @(negedge clk) begin
        logic [31:0] exp_grant;
        logic [31:0] exp_ready;
        if (rst) begin
            m_owner   = -1;
            m_beats   = 0;
            m_block   = 0;
            m_last    = NUM_REQ - 1;
            m_wr_en   = 1'b0;
            m_wr_data = '0;
            m_ovf     = 1'b0;
            checkOutput("rst_grant", 32'(grant), 0);
            checkOutput("rst_ready", 32'(src_ready), 0);
            checkOutput("rst_wr_en", 32'(fifo_wr_en), 0);
            checkOutput("rst_wr_data", 32'(fifo_wr_data), 0);
            checkOutput("rst_ovf", 32'(overflow_err), 0);
        end else begin
            exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
            exp_ready = (m_owner >= 0 && !fifo_wr_full) ? (32'd1 << m_owner) : 32'd0;
            checkOutput("grant", 32'(grant), exp_grant);
            checkOutput("src_ready", 32'(src_ready), exp_ready);
            checkOutput("wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
            if (m_wr_en) checkOutput("wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
            checkOutput("overflow_err", 32'(overflow_err), 32'(m_ovf));
            model_step();
        end
    end

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] v,
                                 input logic f, input logic [DEPTH_WIDTH:0] wl);
        @(posedge clk);
        #1;
        req                 = r;
        src_valid           = v;
        fifo_wr_full        = f;
        fifo_wr_water_level = wl;
        src_data            = $urandom;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst                 = 1'b1;
        req                 = '0;
        src_valid           = '0;
        fifo_wr_full        = 1'b0;
        fifo_wr_water_level = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int   writes;
        int   grant_cycles;
        int   full_left;
        logic full_done;
        logic found;
        logic [NUM_REQ-1:0] prev_grant;
        logic [NUM_REQ-1:0] seq [5];
        int   nseq;
        int   gap;
        int   min_gap;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester, full burst with continuous valid.
        applyStimulus(4'b0010, 4'b1111, 1'b0, 9'd0);
        @(negedge clk);
        checkOutput("t1_grant_before", 32'(grant), 0);
        applyStimulus(4'b0010, 4'b1111, 1'b0, 9'd0);
        @(negedge clk);
        checkOutput("t1_grant_after", 32'(grant), 32'b0010);
        writes = 0;
        grant_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'b0000, 4'b1111, 1'b0, 9'd0);
            @(negedge clk);
            if (i == 0) checkOutput("t1_first_write", 32'(fifo_wr_en), 1);
            if (fifo_wr_en) writes++;
            if (grant != '0) grant_cycles++;
        end
        checkOutput("t1_writes", writes, 16);
        checkOutput("t1_grant_cycles", grant_cycles, 16);

        // Space gating at the free == BURST_LEN boundary.
        do_reset();
        grant_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0001, 4'b1111, 1'b0, 9'd241);
            @(negedge clk);
            if (grant != '0) grant_cycles++;
        end
        checkOutput("t2_no_grant_free15", grant_cycles, 0);
        applyStimulus(4'b0001, 4'b1111, 1'b0, 9'd240);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 9'd240);
        @(negedge clk);
        checkOutput("t2_grant_free16", 32'(grant), 32'b0001);
        repeat (25) applyStimulus(4'b0000, 4'b1111, 1'b0, 9'd0);

        // Valid gaps with a 3-cycle full window that never coincides with a write.
        do_reset();
        applyStimulus(4'b0100, 4'b0000, 1'b0, 9'd0);
        writes    = 0;
        full_left = 0;
        full_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            req       = '0;
            src_valid = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            src_data  = $urandom;
            if (!full_done && writes >= 4 && !fifo_wr_en) begin
                full_done = 1'b1;
                full_left = 3;
            end
            fifo_wr_full = (full_left > 0);
            if (full_left > 0) full_left--;
            @(negedge clk);
            if (fifo_wr_en) writes++;
            if (fifo_wr_full) checkOutput("t3_ready_during_full", 32'(src_ready), 0);
        end
        checkOutput("t3_writes", writes, 16);
        checkOutput("t3_no_overflow", 32'(overflow_err), 0);

        // Full coincident with a registered write must latch overflow_err.
        applyStimulus(4'b0100, 4'b1111, 1'b0, 9'd0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            req = '0;
            if (fifo_wr_en) begin
                fifo_wr_full = 1'b1;
                found = 1'b1;
                break;
            end
        end
        checkOutput("t3_write_seen", 32'(found), 1);
        @(posedge clk);
        #1;
        fifo_wr_full = 1'b0;
        @(negedge clk);
        checkOutput("t3_overflow_set", 32'(overflow_err), 1);
        repeat (20) applyStimulus(4'b0000, 4'b1111, 1'b0, 9'd0);
        @(negedge clk);
        checkOutput("t3_overflow_sticky", 32'(overflow_err), 1);
        do_reset();
        @(negedge clk);
        checkOutput("t3_overflow_cleared", 32'(overflow_err), 0);

        // Reset mid-burst abandons the burst; the next one counts 16 fresh beats.
        applyStimulus(4'b1000, 4'b1111, 1'b0, 9'd0);
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'b0000, 4'b1111, 1'b0, 9'd0);
            @(negedge clk);
            if (fifo_wr_en) writes++;
            if (writes == 7) break;
        end
        checkOutput("t4_pre_reset_writes", writes, 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t4_async_grant", 32'(grant), 0);
        checkOutput("t4_async_wr_en", 32'(fifo_wr_en), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1000, 4'b1111, 1'b0, 9'd0);
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'b0000, 4'b1111, 1'b0, 9'd0);
            @(negedge clk);
            if (fifo_wr_en) writes++;
        end
        checkOutput("t4_fresh_burst_writes", writes, 16);

        // Arbitration order with all requesters active, and with requester 0 idle.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            nseq       = 0;
            prev_grant = '0;
            gap        = 0;
            min_gap    = 1000;
            for (int i = 0; i < 130; i++) begin
                applyStimulus((pass == 0) ? 4'b1111 : 4'b1110, 4'b1111, 1'b0, 9'd0);
                @(negedge clk);
                if (grant != '0 && prev_grant == '0) begin
                    if (nseq > 0 && gap < min_gap) min_gap = gap;
                    if (nseq < 5) seq[nseq] = grant;
                    nseq++;
                end
                if (grant == '0) gap++;
                else gap = 0;
                prev_grant = grant;
            end
            if (pass == 0) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
                checkOutput("t5_seq0", 32'(seq[0]), 32'b0001);
                checkOutput("t5_seq1", 32'(seq[1]), 32'b0001);
                checkOutput("t5_seq2", 32'(seq[2]), 32'b0001);
                checkOutput("t5_seq3", 32'(seq[3]), 32'b0001);
                checkOutput("t5_seq4", 32'(seq[4]), 32'b0001);
`else
                checkOutput("t5_seq0", 32'(seq[0]), 32'b0001);
                checkOutput("t5_seq1", 32'(seq[1]), 32'b0010);
                checkOutput("t5_seq2", 32'(seq[2]), 32'b0100);
                checkOutput("t5_seq3", 32'(seq[3]), 32'b1000);
                checkOutput("t5_seq4", 32'(seq[4]), 32'b0001);
`endif
                checkOutput("t5_min_gap_ok", 32'(min_gap >= 2), 1);
            end else begin
                checkOutput("t5_noreq0_seq0", 32'(seq[0]), 32'b0010);
                checkOutput("t5_noreq0_seq1", 32'(seq[1]), 32'b0100);
                checkOutput("t5_noreq0_seq2", 32'(seq[2]), 32'b1000);
            end
            checkOutput("t5_burst_count", 32'(nseq >= 5), 1);
        end

        // Randomised traffic, FIFO level and occasional resets; the compare process checks every cycle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 999) < 3) begin
                rst = 1'b1;
            end
            req          = NUM_REQ'($urandom);
            src_valid    = NUM_REQ'($urandom) | NUM_REQ'($urandom);
            src_data     = $urandom;
            fifo_wr_full = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 9) < 7) begin
                fifo_wr_water_level = (DEPTH_WIDTH + 1)'($urandom_range(0, 200));
            end else begin
                fifo_wr_water_level = (DEPTH_WIDTH + 1)'($urandom_range(200, CAP));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
